// File: rtl/imsic_msi_arbiter.sv
// imsic_msi_arbiter: round-robin arbiter over MSI requesters feeding a one-entry output stage
// that issues setipnum writes to the targeted interrupt file; invalid requests are dropped and counted.
module imsic_msi_arbiter #(
  parameter int NR_REQ = 4,
  parameter int NR_SRC_LEN = 32,
  parameter int NR_SRC = 64,
  parameter int NR_INTP_FILES = 2,
  localparam int FILE_W = NR_INTP_FILES > 1 ? $clog2(NR_INTP_FILES) : 1,
  localparam int PTR_W = NR_REQ > 1 ? $clog2(NR_REQ) : 1
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic [NR_REQ-1:0]                           i_req_valid,
  input  logic [NR_REQ-1:0][FILE_W-1:0]               i_req_file,
  input  logic [NR_REQ-1:0][NR_SRC_LEN-1:0]           i_req_id,
  output logic [NR_REQ-1:0]                           o_req_ready,
  input  logic [NR_INTP_FILES-1:0]                    i_file_busy,
  output logic [NR_INTP_FILES-1:0][NR_SRC_LEN-1:0]    o_setipnum,
  output logic [NR_INTP_FILES-1:0]                    o_setipnum_we,
  output logic [15:0]                                 o_drop_cnt,
  output logic                                        o_busy
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t                state_q, state_d;
  logic [FILE_W-1:0]     file_q, file_d;
  logic [NR_SRC_LEN-1:0] id_q, id_d;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [15:0]           drop_q, drop_d;
  logic [PTR_W-1:0]      win, idx;
  logic                  found, drain, can_accept, hs, invalid, load;
  logic [FILE_W-1:0]     w_file;
  logic [NR_SRC_LEN-1:0] w_id;
  // Walk offsets from farthest to nearest so the requester closest to rr_q wins.
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(rr_q) + i) % NR_REQ);
      if (i_req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign drain      = state_q == FULL && !i_file_busy[file_q];
  assign can_accept = state_q == EMPTY || drain;
  assign hs         = found && can_accept && !i_rst;
  assign w_file     = i_req_file[win];
  assign w_id       = i_req_id[win];
  assign invalid    = w_id == '0 || w_id >= NR_SRC_LEN'(NR_SRC) || int'(w_file) >= NR_INTP_FILES;
  assign load       = hs && !invalid;
  assign o_req_ready = hs ? NR_REQ'(1) << win : '0;
  always_comb begin
    state_d = load ? FULL : (drain ? EMPTY : state_q);
    file_d  = load ? w_file : file_q;
    id_d    = load ? w_id : id_q;
    rr_d    = hs ? (win == PTR_W'(NR_REQ - 1) ? '0 : win + 1'b1) : rr_q;
    drop_d  = hs && invalid && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
      file_q  <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      file_q  <= file_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end
  for (genvar g = 0; g < NR_INTP_FILES; g++) begin : g_file
    assign o_setipnum_we[g] = drain && file_q == FILE_W'(g);
    assign o_setipnum[g]    = o_setipnum_we[g] ? id_q : '0;
  end
  assign o_drop_cnt = drop_q;
  assign o_busy     = state_q == FULL;
endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// tb_imsic_msi_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_imsic_msi_arbiter;
  localparam int NR_REQ = 4;
  localparam int NF = 3;
  localparam int FW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR_REQ-1:0] valid = '0;
  logic [NR_REQ-1:0][FW-1:0] rfile = '0;
  logic [NR_REQ-1:0][31:0] rid = '0;
  logic [NF-1:0] fbusy = '0;
  logic [NR_REQ-1:0] o_req_ready;
  logic [NF-1:0][31:0] o_setipnum;
  logic [NF-1:0] o_setipnum_we;
  logic [15:0] o_drop_cnt;
  logic o_busy;
  int n_cmp = 0;
  int n_err = 0;
  int m_rr, m_file, m_drops;
  bit m_full;
  logic [31:0] m_id;

  imsic_msi_arbiter #(.NR_REQ(NR_REQ), .NR_SRC_LEN(32), .NR_SRC(64), .NR_INTP_FILES(NF)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_file(rfile), .i_req_id(rid),
    .o_req_ready(o_req_ready), .i_file_busy(fbusy), .o_setipnum(o_setipnum),
    .o_setipnum_we(o_setipnum_we), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy));

  always #5 clk = ~clk;

  function automatic int m_winner();
    if (rst || (m_full && fbusy[m_file])) return -1;
    for (int k = 0; k < NR_REQ; k++)
      if (valid[(m_rr + k) % NR_REQ]) return (m_rr + k) % NR_REQ;
    return -1;
  endfunction

  function automatic bit m_invalid(int r);
    return rid[r] == 0 || rid[r] >= 64 || int'(rfile[r]) >= NF;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rr <= 0; m_full <= 1'b0; m_file <= 0; m_id <= '0; m_drops <= 0;
    end else begin
      automatic int w = m_winner();
      if (w >= 0) m_rr <= (w + 1) % NR_REQ;
      if (w >= 0 && m_invalid(w)) m_drops <= m_drops == 65535 ? 65535 : m_drops + 1;
      if (w >= 0 && !m_invalid(w)) begin
        m_full <= 1'b1; m_file <= int'(rfile[w]); m_id <= rid[w];
      end else if (m_full && !fbusy[m_file]) m_full <= 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    valid = '0; fbusy = '0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; valid = '1; rfile = '0; rid = {32'd4, 32'd3, 32'd2, 32'd1};
    #1;
    n_cmp++; if (o_req_ready !== '0) begin n_err++; $display("FAIL reset_ready got %b want 0", o_req_ready); end
    n_cmp++; if (o_setipnum_we !== '0 || o_setipnum !== '0) begin n_err++; $display("FAIL reset_we got %b/%h want 0", o_setipnum_we, o_setipnum); end
    n_cmp++; if (o_busy !== 1'b0 || o_drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_state got busy %b drop %0d want 0/0", o_busy, o_drop_cnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_resume got %b want 0001", o_req_ready); end
    @(negedge clk);
    valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    valid = 4'b0001; rfile[0] = 2'd1; rid[0] = 32'd5;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b want 0001", o_req_ready); end
    @(negedge clk);
    valid = '0;
    #1;
    n_cmp++; if (o_setipnum_we !== 3'b010) begin n_err++; $display("FAIL single_we got %b want 010", o_setipnum_we); end
    n_cmp++; if (o_setipnum[1] !== 32'd5 || o_setipnum[0] !== 32'd0) begin n_err++; $display("FAIL single_id got %0d/%0d want 5/0", o_setipnum[1], o_setipnum[0]); end
    @(negedge clk);
    #1;
    n_cmp++; if (o_setipnum_we !== '0 || o_busy !== 1'b0) begin n_err++; $display("FAIL single_idle got we %b busy %b want 0/0", o_setipnum_we, o_busy); end
  endtask

  task automatic test_fairness();
    do_reset();
    valid = '1; rfile = '0; rid = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (o_req_ready !== 4'(1 << (c % 4))) begin n_err++; $display("FAIL fair_grant%0d got %b want %b", c, o_req_ready, 4'(1 << (c % 4))); end
      if (c > 0) begin
        n_cmp++; if (o_setipnum_we !== 3'b001 || o_setipnum[0] !== 32'((c - 1) % 4 + 1)) begin n_err++; $display("FAIL fair_we%0d got %b/%0d want 001/%0d", c, o_setipnum_we, o_setipnum[0], (c - 1) % 4 + 1); end
      end
      @(negedge clk);
    end
    valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    valid = 4'b0001; rfile = '0; rid[0] = 32'd7;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_load got %b want 0001", o_req_ready); end
    @(negedge clk);
    valid = 4'b0010; rid[1] = 32'd3; fbusy = 3'b001;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (o_setipnum_we !== '0 || o_req_ready !== '0 || o_busy !== 1'b1) begin n_err++; $display("FAIL bp_stall%0d got we %b ready %b busy %b want 0/0/1", c, o_setipnum_we, o_req_ready, o_busy); end
      @(negedge clk);
    end
    fbusy = '0;
    #1;
    n_cmp++; if (o_setipnum_we !== 3'b001 || o_setipnum[0] !== 32'd7) begin n_err++; $display("FAIL bp_release got %b/%0d want 001/7", o_setipnum_we, o_setipnum[0]); end
    n_cmp++; if (o_req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_next_grant got %b want 0010", o_req_ready); end
    @(negedge clk);
    valid = '0;
    #1;
    n_cmp++; if (o_setipnum_we !== 3'b001 || o_setipnum[0] !== 32'd3) begin n_err++; $display("FAIL bp_second got %b/%0d want 001/3", o_setipnum_we, o_setipnum[0]); end
  endtask

  task automatic test_invalid();
    logic [31:0] ids [3] = '{32'd0, 32'd64, 32'd5};
    logic [FW-1:0] fs [3] = '{2'd0, 2'd0, 2'd3};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      valid = 4'b0001; rid[0] = ids[k]; rfile[0] = fs[k];
      #1;
      n_cmp++; if (o_req_ready !== 4'b0001) begin n_err++; $display("FAIL inv_ack%0d got %b want 0001", k, o_req_ready); end
      @(negedge clk);
      valid = '0;
      #1;
      n_cmp++; if (o_setipnum_we !== '0 || o_busy !== 1'b0 || o_drop_cnt !== 16'(k + 1)) begin n_err++; $display("FAIL inv_drop%0d got we %b busy %b drop %0d want 0/0/%0d", k, o_setipnum_we, o_busy, o_drop_cnt, k + 1); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 4'b0100; rfile = '0; rid[2] = 32'd7; fbusy = 3'b001;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0100) begin n_err++; $display("FAIL rmid_load got %b want 0100", o_req_ready); end
    @(negedge clk);
    valid = '0;
    #1;
    n_cmp++; if (o_busy !== 1'b1 || o_setipnum_we !== '0) begin n_err++; $display("FAIL rmid_held got busy %b we %b want 1/0", o_busy, o_setipnum_we); end
    @(negedge clk);
    valid = 4'b1001; rid[0] = 32'd9; rid[3] = 32'd10; rst = 1'b1;
    #1;
    n_cmp++; if (o_busy !== 1'b0 || o_setipnum_we !== '0 || o_req_ready !== '0) begin n_err++; $display("FAIL rmid_inrst got busy %b we %b ready %b want 0/0/0", o_busy, o_setipnum_we, o_req_ready); end
    @(negedge clk);
    rst = 1'b0; fbusy = '0;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0001 || o_setipnum_we !== '0) begin n_err++; $display("FAIL rmid_restart got ready %b we %b want 0001/0", o_req_ready, o_setipnum_we); end
    @(negedge clk);
    valid = '0;
    #1;
    n_cmp++; if (o_setipnum_we !== 3'b001 || o_setipnum[0] !== 32'd9) begin n_err++; $display("FAIL rmid_issue got %b/%0d want 001/9", o_setipnum_we, o_setipnum[0]); end
  endtask

  task automatic test_random();
    logic [NR_REQ-1:0] granted = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [NR_REQ-1:0] e_ready;
      logic [NF-1:0] e_we;
      logic [NF-1:0][31:0] e_set;
      int w;
      for (int r = 0; r < NR_REQ; r++) begin
        if (!valid[r] || granted[r]) begin
          int sel = int'($urandom_range(0, 9));
          valid[r] = $urandom_range(0, 2) != 0;
          rfile[r] = $urandom_range(0, 7) == 0 ? 2'd3 : FW'($urandom_range(0, 2));
          rid[r] = sel == 0 ? 32'd0 : sel == 1 ? 32'd64 + $urandom_range(0, 1000) : sel == 2 ? 32'd63 : 32'($urandom_range(1, 63));
        end
      end
      for (int f = 0; f < NF; f++) fbusy[f] = $urandom_range(0, 9) < 3;
      #1;
      w = m_winner();
      e_ready = w >= 0 ? 4'(1 << w) : '0;
      e_we = '0; e_set = '0;
      if (m_full && !fbusy[m_file]) begin e_we[m_file] = 1'b1; e_set[m_file] = m_id; end
      n_cmp++; if (o_req_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready c%0d got %b want %b", c, o_req_ready, e_ready); end
      n_cmp++; if (o_setipnum_we !== e_we || o_setipnum !== e_set) begin n_err++; $display("FAIL rnd_write c%0d got %b/%h want %b/%h", c, o_setipnum_we, o_setipnum, e_we, e_set); end
      n_cmp++; if (o_busy !== m_full || o_drop_cnt !== 16'(m_drops)) begin n_err++; $display("FAIL rnd_state c%0d got busy %b drop %0d want %b/%0d", c, o_busy, o_drop_cnt, m_full, m_drops); end
      granted = e_ready;
      @(negedge clk);
    end
    valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    valid = 4'b0001; rid[0] = 32'd0; rfile[0] = '0;
    repeat (65535) @(negedge clk);
    #1;
    n_cmp++; if (o_drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach got %h want ffff", o_drop_cnt); end
    n_cmp++; if (o_req_ready !== 4'b0001) begin n_err++; $display("FAIL sat_ack got %b want 0001", o_req_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (o_drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want ffff", o_drop_cnt); end
    valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imsic_msi_arbiter.md
IMSIC_MSI_ARBITER -- requirements
Module: imsic_msi_arbiter

Interface
REQ-001 SHALL have parameter NR_REQ, default 4, number of MSI requesters.
REQ-002 SHALL have parameter NR_SRC_LEN, default 32, identity field width.
REQ-003 SHALL have parameter NR_SRC, default 64, number of implemented identities (valid identities 1..NR_SRC-1).
REQ-004 SHALL have parameter NR_INTP_FILES, default 2; FILE_W = max(1, clog2(NR_INTP_FILES)).
REQ-005 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_req_valid  input  NR_REQ  per-requester MSI request valid.
REQ-008 SHALL have port i_req_file  input  NR_REQ x FILE_W  target interrupt file index.
REQ-009 SHALL have port i_req_id  input  NR_REQ x NR_SRC_LEN  interrupt identity to set.
REQ-010 SHALL have port o_req_ready  output  NR_REQ  one-hot accept, combinational.
REQ-011 SHALL have port i_file_busy  input  NR_INTP_FILES  target file cannot take a write this cycle.
REQ-012 SHALL have port o_setipnum  output  NR_INTP_FILES x NR_SRC_LEN  identity to target file.
REQ-013 SHALL have port o_setipnum_we  output  NR_INTP_FILES  one-cycle write strobe per file.
REQ-014 SHALL have port o_drop_cnt  output  16  saturating count of dropped invalid requests.
REQ-015 SHALL have port o_busy  output  1  output stage holds a pending write.

Function
REQ-016 SHALL hold a one-entry output stage with state EMPTY or FULL plus registered file and identity.
REQ-017 SHALL define can_accept = (state==EMPTY) or (state==FULL and i_file_busy[held file]==0).
REQ-018 SHALL, when can_accept and any i_req_valid, grant exactly one requester by round-robin starting at pointer rr_ptr, searching rr_ptr, rr_ptr+1, ... modulo NR_REQ.
REQ-019 SHALL assert o_req_ready only for the granted requester, in the same cycle; handshake = valid and ready.
REQ-020 SHALL never assert o_req_ready when can_accept==0 or no request is valid.
REQ-021 SHALL set rr_ptr <= (winner+1) mod NR_REQ on every handshake; rr_ptr unchanged otherwise.
REQ-022 SHALL classify a granted request invalid if id==0, id>=NR_SRC, or file>=NR_INTP_FILES.
REQ-023 SHALL accept (ready) an invalid request, not load it into the output stage, increment o_drop_cnt saturating at 16'hFFFF.
REQ-024 SHALL load a valid granted request into the output stage (state FULL) on the handshake edge.
REQ-025 SHALL, in state FULL with i_file_busy[held file]==0, assert o_setipnum_we[held file]=1 and o_setipnum[held file]=held id for that cycle; all other files' o_setipnum/o_setipnum_we SHALL be 0.
REQ-026 SHALL, in state FULL with i_file_busy[held file]==1, keep the entry, drive o_setipnum_we=0, and stall (no grant).
REQ-027 SHALL, on a FULL-draining cycle with a simultaneous valid handshake, issue the held write and load the new entry (state stays FULL): throughput one write per cycle.
REQ-028 SHALL, on a draining cycle without a new valid load, return to EMPTY.
REQ-029 SHALL have latency exactly one cycle from handshake to o_setipnum_we when the target is not busy.
REQ-030 SHALL drive o_busy = (state==FULL).
REQ-031 SHALL treat i_req_* of non-granted requesters as don't-care; requester holds valid/file/id stable until ready.

Reset
REQ-032 SHALL on i_rst=1, asynchronously: state EMPTY, rr_ptr 0, held file/id 0, o_drop_cnt 0.
REQ-033 SHALL during reset drive o_req_ready=0, o_setipnum_we=0, o_setipnum=0, o_busy=0; a pending write at reset assertion SHALL be discarded, not issued.
REQ-034 SHALL resume arbitration in the first cycle after i_rst deasserts.

Verification
REQ-035 Single: req0 valid file=1 id=5, busy=0 -> ready[0] cycle 0; cycle 1 o_setipnum_we=2'b10, o_setipnum[1]=5.
REQ-036 Fairness: all 4 requesters valid continuously, file 0 ids 1..4 -> grants 0,1,2,3,0 on consecutive cycles, one we[0] per cycle.
REQ-037 Backpressure: held file 0 id 7, i_file_busy[0]=1 for 3 cycles -> no we, no ready for 3 cycles; we[0] with id 7 on cycle busy drops.
REQ-038 Invalid: id=0, then id=64, then file=2 (NR_INTP_FILES=2) -> each acknowledged, no we, o_drop_cnt 1,2,3.
REQ-039 Reset mid-operation: state FULL with busy=1, assert i_rst -> we stays 0, o_busy=0 immediately; after release, req valid id=9 -> normal one-cycle issue, rr_ptr restarted at 0.
REQ-040 Saturation: preload 65535 drops, one more invalid -> o_drop_cnt stays 16'hFFFF.
